// File: rtl/reset_sequencer.sv
// reset_sequencer: holds NUM_STAGES reset domains, waits for a filtered
// PLL lock, then releases the domains in index order with a guard gap.
module reset_sequencer #(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int LOCK_FILTER = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_locked,
   input  logic                  sw_reset_req,
   input  logic [NUM_STAGES-1:0] stage_ready,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic [3:0]            cur_stage,
   output logic                  seq_done,
   output logic                  timeout_err
);

   // One shared counter serves the hold, filter and timeout phases,
   // which never overlap.
   localparam int M1   = (HOLD_CYCLES > LOCK_FILTER) ? HOLD_CYCLES : LOCK_FILTER;
   localparam int MAXC = (M1 > TIMEOUT) ? M1 : TIMEOUT;
   localparam int CW   = $clog2(MAXC + 1) + 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_DONE = CW'(LOCK_FILTER);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
   localparam logic [3:0]    LAST_IDX  = 4'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      S_ASSERT,
      S_WAIT_LOCK,
      S_REL_READY,
      S_REL_GAP,
      S_RUN
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
   logic                  seq_done_q, seq_done_d;
   logic                  err_q, err_d;
   logic                  sync1_q, lock_s_q;
   logic [15:0]           rdy_pad;
   logic                  abort;
   logic                  released;

   assign rdy_pad = 16'(stage_ready);

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= pll_locked;
         lock_s_q <= sync1_q;
      end
   end

   // Next state, counter and registered-output values.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      err_d    = err_q;
      abort    = sw_reset_req ||
                 (!lock_s_q && (state_q == S_REL_READY ||
                                state_q == S_REL_GAP ||
                                state_q == S_RUN));
      if (abort) begin
         state_d = S_ASSERT;
         cnt_d   = '0;
         idx_d   = '0;
         if (sw_reset_req) err_d = 1'b0;
      end else begin
         unique case (state_q)
            S_ASSERT: begin
               if (cnt_q == HOLD_LAST) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_WAIT_LOCK: begin
               if (!lock_s_q) begin
                  cnt_d = '0;
               end else if (cnt_q == LOCK_DONE) begin
                  state_d = S_REL_READY;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_REL_READY: begin
               if (rdy_pad[idx_q]) begin
                  state_d = S_REL_GAP;
                  cnt_d   = '0;
               end else if (cnt_q == TO_LAST) begin
                  state_d = S_REL_GAP;
                  cnt_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_REL_GAP: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d = '0;
                  if (idx_q == LAST_IDX) begin
                     state_d = S_RUN;
                  end else begin
                     state_d = S_REL_READY;
                     idx_d   = idx_q + 4'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_RUN: begin
               state_d = S_RUN;
            end
            default: begin
               state_d = S_ASSERT;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
      released   = (state_d == S_REL_READY) || (state_d == S_REL_GAP);
      seq_done_d = (state_d == S_RUN);
      for (int j = 0; j < NUM_STAGES; j++) begin
         stage_rst_d[j] = !((released && (4'(j) <= idx_d)) ||
                            (state_d == S_RUN));
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_ASSERT;
         cnt_q       <= '0;
         idx_q       <= '0;
         stage_rst_q <= '1;
         seq_done_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         stage_rst_q <= stage_rst_d;
         seq_done_q  <= seq_done_d;
         err_q       <= err_d;
      end
   end

   assign stage_rst   = stage_rst_q;
   assign cur_stage   = idx_q;
   assign seq_done    = seq_done_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed timing scenarios plus randomized traffic
// checked every cycle against a phase-level reference model.
module tb_reset_sequencer;

   localparam int N    = 3;
   localparam int HOLD = 4;
   localparam int LF   = 3;
   localparam int TO   = 10;

   localparam int P_HOLD = 0;
   localparam int P_LOCK = 1;
   localparam int P_WAIT = 2;
   localparam int P_GAP  = 3;
   localparam int P_RUN  = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         pll_locked = 1'b0;
   logic         sw_reset_req = 1'b0;
   logic [N-1:0] stage_ready = '0;
   logic [N-1:0] stage_rst;
   logic [3:0]   cur_stage;
   logic         seq_done;
   logic         timeout_err;

   int tests = 0;
   int fails = 0;

   // reference model state
   int ph, left, streak, waited, released, cur;
   bit err_m, d1, d2;

   // observation marks
   int           rel_e [N];
   int           done_e, err_e, edge_n, a_edge, k;
   logic [N-1:0] prev_rst;
   logic         prev_done, prev_err;

   reset_sequencer #(
      .NUM_STAGES (N),
      .HOLD_CYCLES(HOLD),
      .LOCK_FILTER(LF),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .sw_reset_req(sw_reset_req),
      .stage_ready (stage_ready),
      .stage_rst   (stage_rst),
      .cur_stage   (cur_stage),
      .seq_done    (seq_done),
      .timeout_err (timeout_err)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void model_reset();
      ph       = P_HOLD;
      left     = HOLD;
      streak   = 0;
      waited   = 0;
      released = 0;
      cur      = 0;
      err_m    = 0;
      d1       = 0;
      d2       = 0;
   endfunction

   // One clock edge of the sequence rules, using pre-edge inputs.
   function automatic void model_step();
      bit ls;
      bit abort;
      ls    = d2;
      d2    = d1;
      d1    = pll_locked;
      abort = sw_reset_req || (!ls && ph >= P_WAIT);
      if (abort) begin
         ph       = P_HOLD;
         left     = HOLD;
         released = 0;
         cur      = 0;
         if (sw_reset_req) err_m = 0;
      end else begin
         case (ph)
            P_HOLD: begin
               left--;
               if (left == 0) begin
                  ph     = P_LOCK;
                  streak = 0;
               end
            end
            P_LOCK: begin
               if (!ls) streak = 0;
               else if (streak == LF) begin
                  ph       = P_WAIT;
                  released = 1;
                  cur      = 0;
                  waited   = 0;
               end else streak++;
            end
            P_WAIT: begin
               if (stage_ready[released-1]) begin
                  ph   = P_GAP;
                  left = HOLD;
               end else begin
                  waited++;
                  if (waited == TO) begin
                     err_m = 1;
                     ph    = P_GAP;
                     left  = HOLD;
                  end
               end
            end
            P_GAP: begin
               left--;
               if (left == 0) begin
                  if (released == N) ph = P_RUN;
                  else begin
                     cur = released;
                     released++;
                     ph     = P_WAIT;
                     waited = 0;
                  end
               end
            end
            default: ;
         endcase
      end
   endfunction

   task automatic chk(input string tag);
      logic [N-1:0] er;
      logic         ed;
      for (int j = 0; j < N; j++) er[j] = (j >= released);
      ed = (ph == P_RUN);
      tests++;
      assert (stage_rst === er) else begin
         fails++;
         $error("FAIL %s stage_rst got %b exp %b", tag, stage_rst, er);
      end
      tests++;
      assert (cur_stage === 4'(cur)) else begin
         fails++;
         $error("FAIL %s cur_stage got %0d exp %0d", tag, cur_stage, cur);
      end
      tests++;
      assert (seq_done === ed) else begin
         fails++;
         $error("FAIL %s seq_done got %b exp %b", tag, seq_done, ed);
      end
      tests++;
      assert (timeout_err === err_m) else begin
         fails++;
         $error("FAIL %s timeout_err got %b exp %b", tag, timeout_err, err_m);
      end
   endtask

   task automatic expect_int(input string tag, input int got, input int exp);
      tests++;
      assert (got == exp) else begin
         fails++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic clear_marks();
      for (int j = 0; j < N; j++) rel_e[j] = -1;
      done_e    = -1;
      err_e     = -1;
      prev_rst  = stage_rst;
      prev_done = seq_done;
      prev_err  = timeout_err;
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      #1;
      chk(tag);
      for (int j = 0; j < N; j++)
         if (prev_rst[j] && !stage_rst[j] && rel_e[j] < 0) rel_e[j] = edge_n;
      if (!prev_done && seq_done && done_e < 0) done_e = edge_n;
      if (!prev_err && timeout_err && err_e < 0) err_e = edge_n;
      prev_rst  = stage_rst;
      prev_done = seq_done;
      prev_err  = timeout_err;
      edge_n++;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk(tag);
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
      clear_marks();
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (seq_done !== 1'b1 && n < budget) begin
         cyc(tag);
         n++;
      end
      tests++;
      assert (seq_done === 1'b1) else begin
         fails++;
         $error("FAIL %s seq_done got %b exp 1 (budget expired)", tag, seq_done);
      end
   endtask

   initial begin
      // 1: lock and ready from reset
      #1;
      pll_locked  = 1'b1;
      stage_ready = 3'b111;
      do_reset("t1_reset");
      repeat (25) cyc("t1");
      expect_int("t1_rel0", rel_e[0], 7);
      expect_int("t1_rel1", rel_e[1], 12);
      expect_int("t1_rel2", rel_e[2], 17);
      expect_int("t1_done", done_e, 22);

      // 2: stage 1 never ready -> timeout, sequence still completes
      stage_ready = 3'b101;
      do_reset("t2_reset");
      wait_done("t2", 80);
      expect_int("t2_rel1", rel_e[1], 12);
      expect_int("t2_err", err_e, 22);
      expect_int("t2_err_gap", err_e - rel_e[1], TO);
      expect_int("t2_rel2", rel_e[2], 26);
      expect_int("t2_done", done_e, 31);

      // 4: lock loss in RUN aborts within 3 edges, error kept
      cyc("t4_run");
      pll_locked = 1'b0;
      repeat (3) cyc("t4_loss");
      expect_int("t4_rst_all", int'(stage_rst), 7);
      expect_int("t4_done_low", int'(seq_done), 0);
      expect_int("t4_err_kept", int'(timeout_err), 1);
      pll_locked  = 1'b1;
      stage_ready = 3'b111;
      clear_marks();
      wait_done("t4_reseq", 100);
      expect_int("t4_err_still", int'(timeout_err), 1);

      // 3: one-cycle lock glitch in WAIT_LOCK restarts the filter
      do_reset("t3_reset");
      repeat (5) cyc("t3");
      pll_locked = 1'b0;
      cyc("t3_glitch");
      pll_locked = 1'b1;
      wait_done("t3", 80);
      expect_int("t3_rel0", rel_e[0], 11);
      expect_int("t3_done", done_e, 26);

      // 5: sw reset mid REL_GAP(1) with error set
      stage_ready = 3'b101;
      do_reset("t5_reset");
      k = 0;
      while (timeout_err !== 1'b1 && k < 60) begin
         cyc("t5_to");
         k++;
      end
      expect_int("t5_err_edge", err_e, 22);
      repeat (2) cyc("t5_gap");
      sw_reset_req = 1'b1;
      cyc("t5_sw");
      sw_reset_req = 1'b0;
      stage_ready  = 3'b111;
      a_edge = edge_n - 1;
      expect_int("t5_rst_all", int'(stage_rst), 7);
      expect_int("t5_err_clr", int'(timeout_err), 0);
      clear_marks();
      wait_done("t5_reseq", 80);
      expect_int("t5_rel0", rel_e[0], a_edge + 8);
      expect_int("t5_rel1", rel_e[1], a_edge + 13);
      expect_int("t5_rel2", rel_e[2], a_edge + 18);
      expect_int("t5_done", done_e, a_edge + 23);

      // 6: asynchronous reset between edges mid-sequence
      do_reset("t6_reset");
      repeat (14) cyc("t6");
      expect_int("t6_mid", int'(stage_rst), 4);
      #2;
      do_reset("t6_async");

      // randomized traffic against the model
      for (int r = 0; r < 6; r++) begin
         pll_locked   = 1'b1;
         sw_reset_req = 1'b0;
         stage_ready  = '0;
         do_reset("rand_reset");
         for (int c = 0; c < 400; c++) begin
            pll_locked   = ($urandom_range(0, 59) != 0);
            sw_reset_req = ($urandom_range(0, 149) == 0);
            for (int j = 0; j < N; j++)
               stage_ready[j] = ($urandom_range(0, 2) == 0);
            cyc("rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
